// File: rtl/alu_acc_unit.sv
// alu_acc_unit: 8-bit ALU with accumulator (Aku) and carry (CY) registers; ZFLAG_EN adds a zero-flag register
module alu_acc_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [2:0]       ALUCode,
    input  logic [WIDTH-1:0] R,
    input  logic             A_CE,
    input  logic             CY_CE,
    output logic [WIDTH-1:0] A_out,
    output logic             CY_out,
    output logic [WIDTH-1:0] ALU_out,
`ifdef ZFLAG_EN
    output logic             Z_out,
`endif
    output logic             Co
);
    logic [WIDTH-1:0] a_q, a_d;
    logic             cy_q, cy_d;
    logic [WIDTH:0]   res;
    logic [WIDTH:0]   ci_ext;

    assign ci_ext = {{WIDTH{1'b0}}, cy_q};

    // ALU: one bit wider than the datapath so the top bit carries carry/borrow out
    always_comb begin
        res = '0;
        case (ALUCode)
            3'b000:  res = {1'b0, a_q} + {1'b0, R};
            3'b001:  res = {1'b0, a_q} - {1'b0, R};
            3'b010:  res = {1'b0, a_q} + {1'b0, R} + ci_ext;
            3'b011:  res = {1'b0, a_q} - {1'b0, R} - ci_ext;
            3'b100:  res = {1'b0, a_q & R};
            3'b101:  res = {1'b0, a_q | R};
            3'b110:  res = {1'b0, a_q ^ R};
            default: res = {1'b0, R};
        endcase
    end

    assign ALU_out = res[WIDTH-1:0];
    assign Co      = res[WIDTH];
    assign a_d     = A_CE ? ALU_out : a_q;
    assign cy_d    = CY_CE ? Co : cy_q;
    assign A_out   = a_q;
    assign CY_out  = cy_q;

    // Accumulator and carry registers; reset overrides both enables
    always_ff @(posedge clk) begin
        if (Reset) begin
            a_q  <= '0;
            cy_q <= 1'b0;
        end else begin
            a_q  <= a_d;
            cy_q <= cy_d;
        end
    end

`ifdef ZFLAG_EN
    logic z_q, z_d;

    assign z_d   = CY_CE ? (ALU_out == '0) : z_q;
    assign Z_out = z_q;

    // Zero flag shares the carry enable so both flags describe the same operation
    always_ff @(posedge clk) begin
        if (Reset) z_q <= 1'b0;
        else       z_q <= z_d;
    end
`endif
endmodule

// File: tb/tb_alu_acc_unit.sv
// tb_alu_acc_unit: directed-vector bench for alu_acc_unit
module tb_alu_acc_unit;
    logic       clk = 1'b0;
    logic       Reset;
    logic [2:0] ALUCode;
    logic [7:0] R;
    logic       A_CE, CY_CE;
    logic [7:0] A_out, ALU_out;
    logic       CY_out, Co;
`ifdef ZFLAG_EN
    logic       Z_out;
`endif
    int n_total = 0;
    int n_pass  = 0;

    alu_acc_unit #(.WIDTH(8)) dut (
        .clk(clk), .Reset(Reset), .ALUCode(ALUCode), .R(R),
        .A_CE(A_CE), .CY_CE(CY_CE), .A_out(A_out), .CY_out(CY_out),
        .ALU_out(ALU_out),
`ifdef ZFLAG_EN
        .Z_out(Z_out),
`endif
        .Co(Co)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [2:0] code, input logic [7:0] r);
        ALUCode = code;
        R = r;
        #1;
    endtask

    initial begin
        Reset = 1'b1; A_CE = 1'b1; CY_CE = 1'b1; ALUCode = 3'b000; R = 8'h04;
        step();
        check("rst_a", A_out, 8'h00);
        check("rst_cy", CY_out, 1'b0);
`ifdef ZFLAG_EN
        check("rst_z", Z_out, 1'b0);
`endif
        Reset = 1'b0;
        step(); check("add1", A_out, 8'h04);
        step(); check("add2", A_out, 8'h08);
        check("add2_cy", CY_out, 1'b0);

        op(3'b001, 8'h04);
        check("sub_comb", ALU_out, 8'h04);
        step(); check("sub1", A_out, 8'h04); check("sub1_cy", CY_out, 1'b0);
        step(); check("sub2", A_out, 8'h00); check("sub2_cy", CY_out, 1'b0);
`ifdef ZFLAG_EN
        check("sub2_z", Z_out, 1'b1);
`endif
        check("sub_borrow_comb", Co, 1'b1);
        step(); check("sub3", A_out, 8'hFC); check("sub3_cy", CY_out, 1'b1);
`ifdef ZFLAG_EN
        check("sub3_z", Z_out, 1'b0);
`endif

        op(3'b111, 8'hFC);
        step(); check("ld", A_out, 8'hFC); check("ld_cy", CY_out, 1'b0);
        op(3'b000, 8'h04);
        check("add_wrap_comb", ALU_out, 8'h00);
        step(); check("add_wrap", A_out, 8'h00); check("add_wrap_cy", CY_out, 1'b1);
        op(3'b010, 8'h00);
        check("adc_comb", ALU_out, 8'h01);
        step(); check("adc", A_out, 8'h01); check("adc_cy", CY_out, 1'b0);

        op(3'b111, 8'hF0);
        step(); check("ld_f0", A_out, 8'hF0);
        op(3'b100, 8'h3C); check("and", ALU_out, 8'h30); check("and_co", Co, 1'b0);
        op(3'b101, 8'h3C); check("or", ALU_out, 8'hFC);  check("or_co", Co, 1'b0);
        op(3'b110, 8'h3C); check("xor", ALU_out, 8'hCC); check("xor_co", Co, 1'b0);

        A_CE = 1'b0; CY_CE = 1'b0;
        op(3'b000, 8'h10);
        check("hold_comb", ALU_out, 8'h00);
        check("hold_co", Co, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_a", A_out, 8'hF0);
            check("hold_cy", CY_out, 1'b0);
        end

        A_CE = 1'b1;
        op(3'b000, 8'h01);
        step(); check("a_only", A_out, 8'hF1); check("a_only_cy", CY_out, 1'b0);
        A_CE = 1'b0; CY_CE = 1'b1;
        op(3'b000, 8'h20);
        step(); check("cy_only_a", A_out, 8'hF1); check("cy_only_cy", CY_out, 1'b1);

        A_CE = 1'b1;
        op(3'b011, 8'h01);
        check("sbc_comb", ALU_out, 8'hEF);
        step(); check("sbc", A_out, 8'hEF); check("sbc_cy", CY_out, 1'b0);

        op(3'b000, 8'h01);
        Reset = 1'b1;
        step(); check("mid_rst_a", A_out, 8'h00); check("mid_rst_cy", CY_out, 1'b0);
        Reset = 1'b0;
        step(); check("restart1", A_out, 8'h01);
        step(); check("restart2", A_out, 8'h02);

        op(3'b011, 8'h02);
        step(); check("sbc_zero", A_out, 8'h00); check("sbc_zero_cy", CY_out, 1'b0);
`ifdef ZFLAG_EN
        check("sbc_zero_z", Z_out, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_acc_unit.md
Name: alu_acc_unit

Overview:
- Datapath core of the microprocessor. It combines an 8-bit combinational ALU, the accumulator register (Aku) and the carry register (CY).
- The accumulator feeds the ALU A operand; the ALU result and carry-out are written back to Aku and CY on clock enables.
- The R operand comes from the register file / operand bus.

Parameters:
- WIDTH, 8, datapath width of the accumulator, the R operand and the ALU result.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- ALUCode  input  3  operation select (see Behaviour).
- R  input  WIDTH  second operand.
- A_CE  input  1  accumulator write enable.
- CY_CE  input  1  carry register write enable.
- A_out  output  WIDTH  accumulator contents (ALU A operand).
- CY_out  output  1  carry register contents (ALU carry-in).
- ALU_out  output  WIDTH  combinational ALU result, before registering.
- Co  output  1  combinational ALU carry/borrow out.

Behaviour:
- Reset (sampled on rising clk while Reset=1): A_out=0, CY_out=0. Reset has priority over A_CE/CY_CE.
- Ci is internal and equals CY_out.
- ALU is purely combinational from A_out, R, Ci and ALUCode. ALU_out and Co update in the same cycle as any input change.
- ALUCode map (sums computed WIDTH+1 bits wide; Co = bit WIDTH):
  - 000 ADD: A+R, Co=carry.
  - 001 SUB: A-R, Co=1 on borrow (A<R unsigned).
  - 010 ADC: A+R+Ci, Co=carry.
  - 011 SBC: A-R-Ci, Co=1 on borrow.
  - 100 AND: A&R, Co=0.
  - 101 OR: A|R, Co=0.
  - 110 XOR: A^R, Co=0.
  - 111 LD: R passthrough, Co=0.
- Results wrap modulo 2^WIDTH.
- Register update on rising clk when Reset=0:
  - A_CE=1: A_out <= ALU_out.
  - CY_CE=1: CY_out <= Co.
  - A cleared enable holds that register's value.
- A_CE and CY_CE are independent. Both registers sample the same pre-edge ALU values, so there are no read-after-write hazards within a cycle.
- Latency: one clock from operand/code change to registered result.
- With A_CE=1 held and ALUCode constant, the accumulator iterates every cycle (e.g. ADD accumulates R each edge).
- Reset asserted mid-sequence clears both registers at the next edge regardless of enables. Operation resumes from A=0, CY=0 on the first edge after deassertion.
- No X propagation: ALUCode values outside the map cannot occur (full 3-bit decode).

Optional Feature:
- Macro ZFLAG_EN.
- Defined:
  - Adds output Z_out (1 bit), a zero-flag register.
  - Reset value 0.
  - When CY_CE=1 it loads (ALU_out==0) on the rising edge; it holds otherwise.
- Not defined: no Z_out port and no zero-flag logic.

Test Plan:
- Reset=1 for one edge with A_CE=CY_CE=1 -> A_out=0x00, CY_out=0. Deassert Reset, ALUCode=000, R=4 -> A_out=0x04 after 1st edge, 0x08 after 2nd.
- From A=0x08, ALUCode=001, R=4, one edge -> A_out=0x04, CY_out=0. Repeat twice more -> 0x00 then 0xFC with CY_out=1 (borrow).
- Load A=0xFC via LD (111, R=0xFC), then ADD R=0x04 -> A_out=0x00, CY_out=1. Then ADC R=0x00 -> A_out=0x01, CY_out=0.
- A=0xF0, R=0x3C: AND->0x30, OR->0xFC, XOR->0xCC, Co=0 each; check ALU_out combinationally before the edge.
- A_CE=0, CY_CE=0, ADD R=0x10 over 3 edges -> A_out and CY_out unchanged; ALU_out=A+0x10 combinationally.
- Reset pulsed one cycle during accumulation with enables high -> A_out=0, CY_out=0 at that edge. Accumulation restarts from 0 next edge. With ZFLAG_EN, Z_out=1 after SUB yields 0x00.
